// File: rtl/m_meip_ctrl_if.sv
// Wishbone-classic register port used by the external-interrupt aggregator.
// The bus master drives the request side; the aggregator returns data and acknowledge.
interface m_meip_ctrl_if;
   logic        CYC_I;
   logic        STB_I;
   logic        WE_I;
   logic [1:0]  ADR_I;
   logic [31:0] DAT_I;
   logic [31:0] DAT_O;
   logic        ACK_O;

   modport master (
      output CYC_I, STB_I, WE_I, ADR_I, DAT_I,
      input  DAT_O, ACK_O
   );

   modport slave (
      input  CYC_I, STB_I, WE_I, ADR_I, DAT_I,
      output DAT_O, ACK_O
   );
endinterface

// File: rtl/m_meip_ctrl.sv
// External-interrupt aggregator: synchronises irq lines, latches level/edge pending bits
// and offers claim/complete over a Wishbone slave; meip is the registered OR of claimable sources.
module m_meip_ctrl #(
   parameter int NSRC       = 8,
   parameter int SYNCSTAGES = 2
) (
   input  logic            CLK_I,
   input  logic            RST_I,
   input  logic [NSRC-1:0] irq_i,
   m_meip_ctrl_if.slave    wb,
   output logic            meip
);

   logic [NSRC-1:0] sync_q [SYNCSTAGES];
   logic [NSRC-1:0] sync_d [SYNCSTAGES];
   logic [NSRC-1:0] h_q, h_d;
   logic [NSRC-1:0] pending_q, pending_d;
   logic [NSRC-1:0] enable_q, enable_d;
   logic [NSRC-1:0] edge_q, edge_d;
   logic [NSRC-1:0] inflight_q, inflight_d;
   logic            ack_q, ack_d;
   logic [31:0]     dat_q, dat_d;
   logic            meip_q, meip_d;

   logic [NSRC-1:0] s;
   logic [NSRC-1:0] c;
   logic [NSRC-1:0] claim_oh;
   logic [NSRC-1:0] edge_set;
   logic [NSRC-1:0] clr;
   logic [4:0]      claim_id;
   logic            acc;
   logic            wr_pend, wr_en, wr_edge, wr_cc, rd_claim;
   logic            unused_dat;

   assign unused_dat = ^wb.DAT_I;

   always_comb begin
      sync_d[0] = irq_i;
      for (int i = 1; i < SYNCSTAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   assign s = sync_q[SYNCSTAGES-1];

   always_comb begin
      acc      = wb.CYC_I & wb.STB_I & ~ack_q;
      wr_pend  = acc &  wb.WE_I & (wb.ADR_I == 2'd0);
      wr_en    = acc &  wb.WE_I & (wb.ADR_I == 2'd1);
      wr_edge  = acc &  wb.WE_I & (wb.ADR_I == 2'd2);
      wr_cc    = acc &  wb.WE_I & (wb.ADR_I == 2'd3);
      rd_claim = acc & ~wb.WE_I & (wb.ADR_I == 2'd3);

      c        = pending_q & enable_q & ~inflight_q;
      // isolate the lowest set bit: source 1 has the highest priority
      claim_oh = c & (~c + NSRC'(1));
      claim_id = 5'd0;
      for (int k = NSRC - 1; k >= 0; k--) begin
         if (c[k]) claim_id = 5'(k + 1);
      end

      h_d      = s;
      edge_set = s & ~h_q;
      clr      = (wr_pend ? wb.DAT_I[NSRC-1:0] : '0) | (rd_claim ? claim_oh : '0);
      // level bits track the synchronised line; edge bits hold until cleared, set beats clear
      pending_d = (edge_q & (edge_set | (pending_q & ~clr))) | (~edge_q & s);

      enable_d = wr_en   ? wb.DAT_I[NSRC-1:0] : enable_q;
      edge_d   = wr_edge ? wb.DAT_I[NSRC-1:0] : edge_q;

      inflight_d = inflight_q | (rd_claim ? claim_oh : '0);
      for (int k = 0; k < NSRC; k++) begin
         if (wr_cc && (wb.DAT_I[4:0] == 5'(k + 1))) inflight_d[k] = 1'b0;
      end

      ack_d = acc;
      dat_d = 32'd0;
      if (acc && !wb.WE_I) begin
         case (wb.ADR_I)
            2'd0:    dat_d = 32'(pending_q);
            2'd1:    dat_d = 32'(enable_q);
            2'd2:    dat_d = 32'(edge_q);
            default: dat_d = 32'(claim_id);
         endcase
      end

      meip_d = |c;
   end

   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         for (int i = 0; i < SYNCSTAGES; i++) sync_q[i] <= '0;
         h_q        <= '0;
         pending_q  <= '0;
         enable_q   <= '0;
         edge_q     <= '0;
         inflight_q <= '0;
         ack_q      <= 1'b0;
         dat_q      <= 32'd0;
         meip_q     <= 1'b0;
      end else begin
         for (int i = 0; i < SYNCSTAGES; i++) sync_q[i] <= sync_d[i];
         h_q        <= h_d;
         pending_q  <= pending_d;
         enable_q   <= enable_d;
         edge_q     <= edge_d;
         inflight_q <= inflight_d;
         ack_q      <= ack_d;
         dat_q      <= dat_d;
         meip_q     <= meip_d;
      end
   end

   always_comb begin
      wb.ACK_O = ack_q;
      wb.DAT_O = dat_q;
      meip     = meip_q;
   end

endmodule

// File: tb/tb_m_meip_ctrl.sv
// Directed self-checking bench for m_meip_ctrl (NSRC=8, SYNCSTAGES=2).
module tb_m_meip_ctrl;
   logic       CLK_I = 1'b0;
   logic       RST_I;
   logic [7:0] irq_i;
   logic       meip;
   int         checks   = 0;
   int         failures = 0;
   logic [31:0] rd;

   m_meip_ctrl_if wb ();

   m_meip_ctrl #(.NSRC(8), .SYNCSTAGES(2)) dut (
      .CLK_I (CLK_I),
      .RST_I (RST_I),
      .irq_i (irq_i),
      .wb    (wb.slave),
      .meip  (meip)
   );

   always #5 CLK_I = ~CLK_I;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge CLK_I);
      #1;
   endtask

   // one Wishbone access; called and returning at posedge+1
   task automatic bus(input string tag, input logic we, input logic [1:0] adr,
                      input logic [31:0] wdat, output logic [31:0] rdat);
      int n;
      wb.CYC_I = 1'b1; wb.STB_I = 1'b1; wb.WE_I = we; wb.ADR_I = adr; wb.DAT_I = wdat;
      n = 0;
      do begin
         @(posedge CLK_I); #1; n++;
      end while (!wb.ACK_O && n < 4);
      chk({tag, "_ack_rise"}, {31'd0, wb.ACK_O}, 32'd1);
      rdat = wb.DAT_O;
      wb.CYC_I = 1'b0; wb.STB_I = 1'b0; wb.WE_I = 1'b0;
      @(posedge CLK_I); #1;
      chk({tag, "_ack_fall"}, {31'd0, wb.ACK_O}, 32'd0);
      $display("bus %s we=%0d adr=%0d wdat=%h rdat=%h meip=%0d", tag, we, adr, wdat, rdat, meip);
   endtask

   task automatic rd_chk(input string tag, input logic [1:0] adr, input logic [31:0] exp);
      logic [31:0] d;
      bus(tag, 1'b0, adr, 32'd0, d);
      chk(tag, d, exp);
   endtask

   task automatic wr(input string tag, input logic [1:0] adr, input logic [31:0] wdat);
      logic [31:0] d;
      bus(tag, 1'b1, adr, wdat, d);
   endtask

   // one-cycle pulse; returns right after the edge that samples it (e1)
   task automatic pulse(input logic [7:0] m);
      irq_i = m;
      cyc(1);
      irq_i = 8'h00;
   endtask

   initial begin
      RST_I = 1'b0; irq_i = 8'h00;
      wb.CYC_I = 1'b0; wb.STB_I = 1'b0; wb.WE_I = 1'b0; wb.ADR_I = 2'd0; wb.DAT_I = 32'd0;
      #3;
      chk("rst_meip", {31'd0, meip}, 32'd0);
      chk("rst_ack",  {31'd0, wb.ACK_O}, 32'd0);
      chk("rst_dat",  wb.DAT_O, 32'd0);
      cyc(2);
      RST_I = 1'b1;
      cyc(1);
      rd_chk("rst_pend", 2'd0, 32'd0);
      rd_chk("rst_en",   2'd1, 32'd0);
      rd_chk("rst_edge", 2'd2, 32'd0);
      rd_chk("rst_claim",2'd3, 32'd0);
      chk("rst_meip2", {31'd0, meip}, 32'd0);

      // edge source 1: latency and claim/complete
      wr("t2_edge", 2'd2, 32'h01);
      wr("t2_en",   2'd1, 32'h01);
      pulse(8'h01);
      cyc(2);
      chk("t2_meip_e3", {31'd0, meip}, 32'd0);
      cyc(1);
      chk("t2_meip_e4", {31'd0, meip}, 32'd1);
      rd_chk("t2_claim1", 2'd3, 32'd1);
      chk("t2_meip_low", {31'd0, meip}, 32'd0);
      rd_chk("t2_claim0", 2'd3, 32'd0);
      wr("t2_complete", 2'd3, 32'd1);
      pulse(8'h01);
      cyc(3);
      chk("t2_meip_again", {31'd0, meip}, 32'd1);
      rd_chk("t2_claim_again", 2'd3, 32'd1);
      wr("t2_complete2", 2'd3, 32'd1);

      // level sources 3 and 6
      wr("t3_edge", 2'd2, 32'h00);
      wr("t3_en",   2'd1, 32'hFF);
      irq_i = 8'h24;
      cyc(4);
      chk("t3_meip", {31'd0, meip}, 32'd1);
      rd_chk("t3_claim3", 2'd3, 32'd3);
      rd_chk("t3_claim6", 2'd3, 32'd6);
      rd_chk("t3_claim0", 2'd3, 32'd0);
      chk("t3_meip_low", {31'd0, meip}, 32'd0);
      wr("t3_complete3", 2'd3, 32'd3);
      chk("t3_meip_reassert", {31'd0, meip}, 32'd1);
      rd_chk("t3_claim3b", 2'd3, 32'd3);
      wr("t3_complete3b", 2'd3, 32'd3);
      wr("t3_complete6",  2'd3, 32'd6);
      irq_i = 8'h00;
      cyc(5);
      chk("t3_meip_drop", {31'd0, meip}, 32'd0);
      rd_chk("t3_pend", 2'd0, 32'd0);

      // disabled edge source 2, then enable, then W1C
      wr("t4_edge", 2'd2, 32'h02);
      wr("t4_en",   2'd1, 32'h00);
      pulse(8'h02);
      cyc(3);
      rd_chk("t4_pend", 2'd0, 32'h02);
      chk("t4_meip_masked", {31'd0, meip}, 32'd0);
      wr("t4_en2", 2'd1, 32'h02);
      chk("t4_meip_en", {31'd0, meip}, 32'd1);
      wr("t4_w1c", 2'd0, 32'h02);
      chk("t4_meip_w1c", {31'd0, meip}, 32'd0);
      rd_chk("t4_pend2", 2'd0, 32'h00);

      // new edge on the claim edge of source 1
      wr("t5_edge", 2'd2, 32'h01);
      wr("t5_en",   2'd1, 32'h01);
      pulse(8'h01);
      cyc(5);
      chk("t5_meip", {31'd0, meip}, 32'd1);
      pulse(8'h01);
      cyc(1);
      rd_chk("t5_claim", 2'd3, 32'd1);
      chk("t5_meip_inflight", {31'd0, meip}, 32'd0);
      rd_chk("t5_pend", 2'd0, 32'h01);
      wr("t5_complete", 2'd3, 32'd1);
      chk("t5_meip_after", {31'd0, meip}, 32'd1);
      rd_chk("t5_claim2", 2'd3, 32'd1);
      wr("t5_complete2", 2'd3, 32'd1);

      // reset mid-access with everything pending
      wr("t6_edge", 2'd2, 32'hFF);
      wr("t6_en",   2'd1, 32'hFF);
      pulse(8'hFF);
      cyc(4);
      chk("t6_meip_pre", {31'd0, meip}, 32'd1);
      wb.CYC_I = 1'b1; wb.STB_I = 1'b1; wb.WE_I = 1'b0; wb.ADR_I = 2'd0;
      cyc(1);
      chk("t6_ack_pre", {31'd0, wb.ACK_O}, 32'd1);
      chk("t6_dat_pre", wb.DAT_O, 32'hFF);
      #1 RST_I = 1'b0;
      #1;
      chk("t6_ack_rst",  {31'd0, wb.ACK_O}, 32'd0);
      chk("t6_dat_rst",  wb.DAT_O, 32'd0);
      chk("t6_meip_rst", {31'd0, meip}, 32'd0);
      cyc(2);
      chk("t6_ack_hold", {31'd0, wb.ACK_O}, 32'd0);
      wb.CYC_I = 1'b0; wb.STB_I = 1'b0;
      RST_I = 1'b1;
      cyc(1);
      rd_chk("t6_pend",  2'd0, 32'd0);
      rd_chk("t6_en",    2'd1, 32'd0);
      rd_chk("t6_edge",  2'd2, 32'd0);
      rd_chk("t6_claim", 2'd3, 32'd0);

      // completes with out-of-range ids leave INFLIGHT alone
      wr("t7_edge", 2'd2, 32'h01);
      wr("t7_en",   2'd1, 32'h01);
      pulse(8'h01);
      cyc(4);
      rd_chk("t7_claim", 2'd3, 32'd1);
      pulse(8'h01);
      cyc(4);
      chk("t7_meip_inflight", {31'd0, meip}, 32'd0);
      wr("t7_cmp0", 2'd3, 32'd0);
      chk("t7_meip_id0", {31'd0, meip}, 32'd0);
      wr("t7_cmp9", 2'd3, 32'd9);
      chk("t7_meip_id9", {31'd0, meip}, 32'd0);
      wr("t7_cmp1", 2'd3, 32'd1);
      chk("t7_meip_id1", {31'd0, meip}, 32'd1);
      rd_chk("t7_claim2", 2'd3, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
